// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    localparam logic [31:0] ABORT_DATA_DEFAULT = 32'hffffffff;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker: pick is combinational from requests and last grant.
// Latency: 0 cycles for pick; last_grant moves on the edge after an upd strobe.
// Backpressure: none; the caller decides when a grant is consumed via upd.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    input  logic upd_grant,
    output logic pick
);

    logic last_q;
    logic last_d;

    always_comb begin
        last_d = last_q;
        if (upd) begin
            last_d = upd_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= GRANT_I;
        end else begin
            last_q <= last_d;
        end
    end

    // On a tie the port that did not win last time goes next.
    assign pick = (req0 && req1) ? ~last_q : (req1 ? GRANT_D : GRANT_I);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data ports.
// Latency: request sampled in IDLE -> m_req next cycle; port ack one cycle after m_ack.
// Backpressure: req/ack handshakes; a watchdog aborts with ABORT_DATA after TIMEOUT busy cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned  TIMEOUT    = 255,
    parameter logic [31:0]  ABORT_DATA = ABORT_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_rw,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        err
);

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    logic [1:0]  state_q,   state_d;
    logic        grant_q,   grant_d;
    mreq_t       mreq_q,    mreq_d;
    logic        m_req_q,   m_req_d;
    logic [15:0] cnt_q,     cnt_d;
    logic        i_ack_q,   i_ack_d;
    logic        d_ack_q,   d_ack_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        err_q,     err_d;
    logic        upd;
    logic        pick;

    rr_arb2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req0      (i_req),
        .req1      (d_req),
        .upd       (upd),
        .upd_grant (grant_q),
        .pick      (pick)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        mreq_d    = mreq_q;
        m_req_d   = m_req_q;
        cnt_d     = cnt_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;
        upd       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    grant_d = pick;
                    if (pick == GRANT_D) begin
                        mreq_d = '{rw: d_rw, addr: d_addr, wdata: d_wdata};
                    end else begin
                        mreq_d = '{rw: 1'b0, addr: i_addr, wdata: 32'h0};
                    end
                    m_req_d = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 16'd1;
                // m_ack is checked first so a tie with the watchdog completes normally.
                if (m_ack) begin
                    m_req_d = 1'b0;
                    upd     = 1'b1;
                    state_d = ST_RESP;
                    if (grant_q == GRANT_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = m_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mreq_q.rw) begin
                            d_rdata_d = m_rdata;
                        end
                    end
                end else if (cnt_d == TO_LIM) begin
                    m_req_d = 1'b0;
                    upd     = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                    if (grant_q == GRANT_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = ABORT_DATA;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = ABORT_DATA;
                    end
                end
            end
            ST_RESP: begin
                cnt_d   = 16'd0;
                state_d = ST_IDLE;
            end
            default: begin
                m_req_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= GRANT_I;
            mreq_q    <= '0;
            m_req_q   <= 1'b0;
            cnt_q     <= 16'd0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            mreq_q    <= mreq_d;
            m_req_q   <= m_req_d;
            cnt_q     <= cnt_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_rw    = mreq_q.rw;
    assign m_addr  = mreq_q.addr;
    assign m_wdata = mreq_q.wdata;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, reset/idle corner sequences, random transactions.
module tb_mem_arbiter;

    localparam int          TO    = 8;
    localparam logic [31:0] ABORT = 32'hffffffff;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_rw, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic        i_ack, d_ack, m_req, m_rw, err;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

    int total = 0;
    int bad   = 0;

    // Transaction-level shadow of the arbiter's visible state.
    logic        model_last;
    logic [31:0] exp_i_rdata, exp_d_rdata;
    logic        exp_err;

    mem_arbiter #(.TIMEOUT(TO), .ABORT_DATA(ABORT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ir, dr, drw;
        logic [31:0] ia, da, wd, mrd;
        int          dly;
        logic        exp_g;
        logic        exp_ab;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_last  = 1'b0;
        exp_i_rdata = 32'h0;
        exp_d_rdata = 32'h0;
        exp_err     = 1'b0;
    endtask

    // Entered #1 after an edge with the DUT idle; returns #1 after the edge closing RESP.
    task automatic txn(input logic ir, input logic dr, input logic drw,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] wd, input logic [31:0] mrd,
                       input int dly, input logic g, input logic ab);
        logic [31:0] ea, ew;
        logic        er;
        int          len;
        ea  = g ? da : ia;
        er  = g ? drw : 1'b0;
        ew  = g ? wd : 32'h0;
        len = ab ? TO : dly + 1;
        i_req = ir; d_req = dr; d_rw = drw;
        i_addr = ia; d_addr = da; d_wdata = wd; m_ack = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= len; c++) begin
            m_ack   = (c == dly + 1);
            m_rdata = (c == dly + 1) ? mrd : $urandom;
            @(negedge clk);
            chk("busy_m_req", m_req, 1);
            chk("busy_m_addr", m_addr, ea);
            chk("busy_m_rw", m_rw, er);
            chk("busy_m_wdata", m_wdata, ew);
            chk("busy_acks", {i_ack, d_ack}, 0);
            @(posedge clk); #1;
        end
        m_ack = 1'b0;
        if (g == 1'b0)  exp_i_rdata = ab ? ABORT : mrd;
        else if (ab)    exp_d_rdata = ABORT;
        else if (!drw)  exp_d_rdata = mrd;
        if (ab) exp_err = 1'b1;
        model_last = g;
        @(negedge clk);
        chk("resp_m_req", m_req, 0);
        chk("resp_i_ack", i_ack, (g == 1'b0));
        chk("resp_d_ack", d_ack, (g == 1'b1));
        chk("resp_i_rdata", i_rdata, exp_i_rdata);
        chk("resp_d_rdata", d_rdata, exp_d_rdata);
        chk("resp_err", err, exp_err);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            m_ack   = $urandom_range(0, 1);
            m_rdata = $urandom;
            @(negedge clk);
            chk({nm, "_m_req"}, m_req, 0);
            chk({nm, "_acks"}, {i_ack, d_ack}, 0);
            chk({nm, "_rdata"}, {i_rdata ^ d_rdata}, exp_i_rdata ^ exp_d_rdata);
            chk({nm, "_err"}, err, exp_err);
            @(posedge clk); #1;
        end
        m_ack = 1'b0;
    endtask

    initial begin
        logic        ir, dr, drw, g, ab;
        logic [1:0]  r;
        int          dly;

        // ir dr drw  ia         da         wd         mrd        dly g  ab
        vt[0] = '{1, 0, 0, 32'h100, 32'h0,   32'h0,      32'h0a5a5a5a, 0,   0, 0};
        vt[1] = '{1, 1, 1, 32'h104, 32'h200, 32'h1111,   32'h0bad0001, 0,   1, 0};
        vt[2] = '{1, 1, 1, 32'h104, 32'h204, 32'h2222,   32'h0c0c0c0c, 0,   0, 0};
        vt[3] = '{1, 1, 1, 32'h108, 32'h208, 32'h3333,   32'h0bad0002, 0,   1, 0};
        vt[4] = '{1, 1, 1, 32'h108, 32'h20c, 32'h4444,   32'h0d0d0d0d, 0,   0, 0};
        vt[5] = '{0, 1, 0, 32'h0,   32'h300, 32'h0,      32'h12345678, 5,   1, 0};
        vt[6] = '{1, 0, 0, 32'h400, 32'h0,   32'h0,      32'h87654321, 7,   0, 0};
        vt[7] = '{0, 1, 0, 32'h0,   32'h500, 32'h0,      32'h0,        100, 1, 1};
        vt[8] = '{0, 1, 1, 32'h0,   32'h504, 32'h5555,   32'h0,        100, 1, 1};
        vt[9] = '{1, 1, 1, 32'h600, 32'h604, 32'h6666,   32'h0bad0003, 2,   0, 0};

        reset = 1'b1; i_req = 0; d_req = 0; d_rw = 0; m_ack = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_m_req", m_req, 0);
        chk("rst_m_rw", m_rw, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_acks", {i_ack, d_ack}, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            txn(vt[i].ir, vt[i].dr, vt[i].drw, vt[i].ia, vt[i].da, vt[i].wd,
                vt[i].mrd, vt[i].dly, vt[i].exp_g, vt[i].exp_ab);
        end

        // Stray m_ack while idle must not disturb anything.
        idle_cycles(4, "idle_stray_ack");

        // Reset during BUSY, coinciding with m_ack, then a late m_ack.
        i_req = 1'b1; i_addr = 32'h700;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rmid_busy_m_req", m_req, 1);
        @(posedge clk); #1;
        reset = 1'b1; m_ack = 1'b1; m_rdata = 32'hdeadbeef; i_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; m_ack = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rmid_m_req", m_req, 0);
        chk("rmid_acks", {i_ack, d_ack}, 0);
        chk("rmid_err", err, 0);
        chk("rmid_i_rdata", i_rdata, 0);
        @(posedge clk); #1;
        m_ack = 1'b1; m_rdata = 32'hfeedface;
        @(negedge clk);
        chk("late_ack_m_req", m_req, 0);
        chk("late_ack_acks", {i_ack, d_ack}, 0);
        @(posedge clk); #1;
        m_ack = 1'b0;
        idle_cycles(2, "post_rst");
        txn(1, 1, 0, 32'h800, 32'h804, 32'h0, 32'h13579bdf, 1, 1'b1, 1'b0);

        // Random traffic against the transaction-level model.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3), "rnd_idle");
            r   = 2'($urandom_range(1, 3));
            ir  = r[0];
            dr  = r[1];
            drw = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, 10);
            g   = (ir && dr) ? ~model_last : dr;
            ab  = (dly + 1 > TO);
            txn(ir, dr, drw, $urandom, $urandom, $urandom, $urandom, dly, g, ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
